fetch_controller: RTL and testbench

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_credit_counter.sv | 59 +++++
 rtl/fetch_controller.sv | 118 +++++++++++
 tb/tb_fetch_controller.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch controller
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

    localparam int FETCH_BYTES = 8;
    localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_credit_counter.sv
// rtl/fetch_credit_counter.sv - decode-queue credit pool with reload and range checks
module fetch_credit_counter #(
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    i_inc,
    input  logic [1:0]    i_dec,
    input  logic          i_reload,
    output logic [CW-1:0] o_credits,
    output logic [CW-1:0] o_credits_next
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [CW-1:0] r_credits;
    logic [CW:0]   w_up;
    logic [CW:0]   w_diff;
    logic          w_under;
    logic          w_over;

    // Apply the freed entries before the consumed ones so a full pool can still be refilled and drained in one cycle
    always_comb begin
        w_up           = {1'b0, r_credits} + (CW+1)'(i_inc);
        w_under        = w_up < (CW+1)'(i_dec);
        w_diff         = w_up - (CW+1)'(i_dec);
        w_over         = !w_under && (w_diff > (CW+1)'(DEPTH));
        o_credits_next = w_diff[CW-1:0];
        if (i_reload) begin
            o_credits_next = FULL;
        end else if (w_under) begin
            o_credits_next = '0;
        end else if (w_over) begin
            o_credits_next = FULL;
        end
    end

    // Credit register; reset leaves the whole queue free
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_credits <= FULL;
        end else begin
            r_credits <= o_credits_next;
        end
    end

    // Out-of-range updates mean the decode queue and fetch disagree about occupancy
    always @(posedge clk) begin
        if (rst && !i_reload) begin
            assert (i_inc <= 2'd2 && i_dec <= 2'd2);
            assert (!w_under);
            assert (!w_over);
        end
    end

    assign o_credits = r_credits;

endmodule

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - two-wide instruction fetch sequencer with credit flow control
module fetch_controller
    import fetch_pkg::*;
#(
    parameter  int ADDR_WIDTH  = 32,
    parameter  int QUEUE_DEPTH = 8,
    localparam int CW          = $clog2(QUEUE_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic                  flush_valid,
    input  logic [ADDR_WIDTH-1:0] flush_addr,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    input  logic                  halt_req,
    input  logic                  fetch_gnt,
    input  logic [1:0]            deq_count,
    output logic                  fetch_req,
    output logic [ADDR_WIDTH-1:0] fetch_pc,
    output logic [1:0]            fetch_slot_valid,
    output logic                  fetch_epoch,
    output logic [CW-1:0]         credits,
    output fetch_state_t          state
);

    fetch_state_t          r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_epoch;

    fetch_state_t          w_next_state;
    logic [ADDR_WIDTH-1:0] w_next_pc;
    logic                  w_active;
    logic                  w_reload;
    logic                  w_req;
    logic                  w_fire;
    logic [1:0]            w_slot;
    logic [1:0]            w_dec;
    logic [CW-1:0]         w_credits;
    logic [CW-1:0]         w_credits_next;

    // Targets are word addresses; the low two bits are dropped on every load
    function automatic logic [ADDR_WIDTH-1:0] align_word(input logic [ADDR_WIDTH-1:0] a);
        return a & ~ADDR_WIDTH'(3);
    endfunction

    // Request qualification, slot validity and the credit cost of a granted bundle
    always_comb begin
        w_active = (r_state == ST_RUN) || (r_state == ST_STALL);
        w_reload = (r_state != ST_BOOT) && (flush_valid || (redirect_valid && w_active));
        w_req    = (r_state == ST_RUN) && (w_credits >= CW'(2)) && !flush_valid && !redirect_valid;
        w_slot   = 2'b00;
        if (r_state != ST_BOOT) begin
            w_slot = r_pc[2] ? 2'b01 : 2'b11;
        end
        w_fire = w_req && fetch_gnt;
        w_dec  = w_fire ? (2'(w_slot[0]) + 2'(w_slot[1])) : 2'd0;
    end

    fetch_credit_counter #(
        .DEPTH (QUEUE_DEPTH)
    ) u_credits (
        .clk            (clk),
        .rst            (rst),
        .i_inc          (deq_count),
        .i_dec          (w_dec),
        .i_reload       (w_reload),
        .o_credits      (w_credits),
        .o_credits_next (w_credits_next)
    );

    // Single priority chain for state and PC: flush > redirect > halt > grant > hold
    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        if (r_state == ST_BOOT) begin
            w_next_state = ST_RUN;
            w_next_pc    = align_word(start_addr);
        end else if (flush_valid) begin
            w_next_state = ST_RUN;
            w_next_pc    = align_word(flush_addr);
        end else if (redirect_valid && w_active) begin
            w_next_state = ST_RUN;
            w_next_pc    = align_word(redirect_addr);
        end else begin
            // A misaligned bundle only carries slot0, so it steps to the next 8-byte boundary
            if (w_fire) begin
                w_next_pc = r_pc + (r_pc[2] ? ADDR_WIDTH'(INSTR_BYTES) : ADDR_WIDTH'(FETCH_BYTES));
            end
            if (halt_req && w_active) begin
                w_next_state = ST_HALT;
            end else if (w_active) begin
                w_next_state = (w_credits_next >= CW'(2)) ? ST_RUN : ST_STALL;
            end
        end
    end

    // State, PC and epoch registers; the epoch flips whenever the fetch stream is redirected
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_BOOT;
            r_pc    <= '0;
            r_epoch <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
            r_epoch <= r_epoch ^ w_reload;
        end
    end

    assign fetch_req        = w_req;
    assign fetch_pc         = r_pc;
    assign fetch_slot_valid = w_slot;
    assign fetch_epoch      = r_epoch;
    assign credits          = w_credits;
    assign state            = r_state;

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - directed scoreboard bench for fetch_controller
module tb_fetch_controller;
    import fetch_pkg::*;

    localparam int AW = 32;
    localparam int QD = 8;
    localparam int CW = $clog2(QD) + 1;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic          epoch;
        logic [1:0]    slot;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] start_addr;
    logic          flush_valid;
    logic [AW-1:0] flush_addr;
    logic          redirect_valid;
    logic [AW-1:0] redirect_addr;
    logic          halt_req;
    logic          fetch_gnt;
    logic [1:0]    deq_count;
    logic          fetch_req;
    logic [AW-1:0] fetch_pc;
    logic [1:0]    fetch_slot_valid;
    logic          fetch_epoch;
    logic [CW-1:0] credits;
    fetch_state_t  state;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    fetch_controller #(.ADDR_WIDTH(AW), .QUEUE_DEPTH(QD)) dut (
        .clk              (clk),
        .rst              (rst),
        .start_addr       (start_addr),
        .flush_valid      (flush_valid),
        .flush_addr       (flush_addr),
        .redirect_valid   (redirect_valid),
        .redirect_addr    (redirect_addr),
        .halt_req         (halt_req),
        .fetch_gnt        (fetch_gnt),
        .deq_count        (deq_count),
        .fetch_req        (fetch_req),
        .fetch_pc         (fetch_pc),
        .fetch_slot_valid (fetch_slot_valid),
        .fetch_epoch      (fetch_epoch),
        .credits          (credits),
        .state            (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [AW-1:0] pc, input logic ep, input logic [1:0] sl);
        exp_t e;
        e.pc = pc; e.epoch = ep; e.slot = sl;
        exp_q.push_back(e);
    endtask

    // Pops the scoreboard on every accepted request, then advances one clock to the next falling edge
    task automatic tick();
        exp_t e;
        #1;
        if (fetch_req && fetch_gnt) begin
            n_tests++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_unexpected_grant: observed pc 0x%0h expected no grant", fetch_pc);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_pc", 64'(fetch_pc), 64'(e.pc));
                check("sb_epoch", 64'(fetch_epoch), 64'(e.epoch));
                check("sb_slot", 64'(fetch_slot_valid), 64'(e.slot));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_state"}, 64'(state), 64'(ST_BOOT));
        check({tag, "_pc"}, 64'(fetch_pc), 64'd0);
        check({tag, "_req"}, 64'(fetch_req), 64'd0);
        check({tag, "_slot"}, 64'(fetch_slot_valid), 64'd0);
        check({tag, "_epoch"}, 64'(fetch_epoch), 64'd0);
        check({tag, "_credits"}, 64'(credits), 64'(QD));
    endtask

    initial begin
        rst = 1'b0; start_addr = '0; flush_valid = 1'b0; flush_addr = '0;
        redirect_valid = 1'b0; redirect_addr = '0; halt_req = 1'b0;
        fetch_gnt = 1'b0; deq_count = 2'd0;
        @(negedge clk); @(negedge clk);
        #1; check_reset("rst");

        // Boot, then three aligned bundles with the queue draining two per cycle
        rst = 1'b1; start_addr = 32'h100; fetch_gnt = 1'b1;
        #1;
        check("boot_state", 64'(state), 64'(ST_BOOT));
        check("boot_req", 64'(fetch_req), 64'd0);
        tick();
        check("run_state", 64'(state), 64'(ST_RUN));
        deq_count = 2'd2;
        for (int i = 0; i < 3; i++) begin
            push(32'h100 + 32'(8 * i), 1'b0, 2'b11);
            #1;
            check("seq_pc", 64'(fetch_pc), 64'(32'h100 + 32'(8 * i)));
            check("seq_req", 64'(fetch_req), 64'd1);
            check("seq_credits", 64'(credits), 64'(QD));
            tick();
        end

        // Credits run out after four grants without dequeues
        deq_count = 2'd0;
        for (int i = 0; i < 4; i++) begin
            push(32'h118 + 32'(8 * i), 1'b0, 2'b11);
            #1;
            check("drain_credits", 64'(credits), 64'(QD - 2 * i));
            tick();
        end
        #1;
        check("stall_state", 64'(state), 64'(ST_STALL));
        check("stall_credits", 64'(credits), 64'd0);
        check("stall_req", 64'(fetch_req), 64'd0);
        tick();
        check("stall_hold_pc", 64'(fetch_pc), 64'h138);
        check("stall_hold_state", 64'(state), 64'(ST_STALL));
        deq_count = 2'd2;
        tick();
        deq_count = 2'd0; fetch_gnt = 1'b0;
        #1;
        check("unstall_state", 64'(state), 64'(ST_RUN));
        check("unstall_credits", 64'(credits), 64'd2);
        check("unstall_req", 64'(fetch_req), 64'd1);
        tick();
        check("nognt_pc", 64'(fetch_pc), 64'h138);
        check("nognt_slot", 64'(fetch_slot_valid), 64'b11);
        check("nognt_req", 64'(fetch_req), 64'd1);

        // Redirect onto an odd word: single-slot bundle, then realign
        redirect_valid = 1'b1; redirect_addr = 32'h204; fetch_gnt = 1'b1;
        #1;
        check("redir_req", 64'(fetch_req), 64'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("redir_pc", 64'(fetch_pc), 64'h204);
        check("redir_slot", 64'(fetch_slot_valid), 64'b01);
        check("redir_epoch", 64'(fetch_epoch), 64'd1);
        check("redir_credits", 64'(credits), 64'(QD));
        push(32'h204, 1'b1, 2'b01);
        tick();
        check("realign_pc", 64'(fetch_pc), 64'h208);
        check("realign_slot", 64'(fetch_slot_valid), 64'b11);
        check("realign_credits", 64'(credits), 64'(QD - 1));

        // Flush and redirect together: flush target wins, one epoch flip
        fetch_gnt = 1'b0;
        flush_valid = 1'b1; flush_addr = 32'h80;
        redirect_valid = 1'b1; redirect_addr = 32'h300;
        #1;
        check("both_req", 64'(fetch_req), 64'd0);
        tick();
        flush_valid = 1'b0; redirect_valid = 1'b0;
        check("both_pc", 64'(fetch_pc), 64'h80);
        check("both_epoch", 64'(fetch_epoch), 64'd0);
        check("both_credits", 64'(credits), 64'(QD));

        // Halt with a grant in the same cycle, redirect ignored while halted, flush resumes
        fetch_gnt = 1'b1; halt_req = 1'b1;
        push(32'h80, 1'b0, 2'b11);
        #1;
        check("halt_cycle_req", 64'(fetch_req), 64'd1);
        tick();
        halt_req = 1'b0;
        #1;
        check("halt_state", 64'(state), 64'(ST_HALT));
        check("halt_pc", 64'(fetch_pc), 64'h88);
        check("halt_req_out", 64'(fetch_req), 64'd0);
        redirect_valid = 1'b1; redirect_addr = 32'h500;
        tick();
        redirect_valid = 1'b0;
        check("halt_redir_state", 64'(state), 64'(ST_HALT));
        check("halt_redir_pc", 64'(fetch_pc), 64'h88);
        check("halt_redir_epoch", 64'(fetch_epoch), 64'd0);
        flush_valid = 1'b1; flush_addr = 32'h43;
        #1;
        check("halt_flush_req", 64'(fetch_req), 64'd0);
        tick();
        flush_valid = 1'b0;
        check("resume_state", 64'(state), 64'(ST_RUN));
        check("resume_pc", 64'(fetch_pc), 64'h40);
        check("resume_epoch", 64'(fetch_epoch), 64'd1);
        check("resume_credits", 64'(credits), 64'(QD));

        // Asynchronous reset in the middle of a running cycle
        push(32'h40, 1'b1, 2'b11);
        tick();
        check("pre_rst_pc", 64'(fetch_pc), 64'h48);
        check("pre_rst_credits", 64'(credits), 64'(QD - 2));
        #2;
        rst = 1'b0;
        #1;
        check_reset("async");
        fetch_gnt = 1'b0;
        tick();
        check_reset("held");
        rst = 1'b1; start_addr = 32'h1000;
        #1;
        check("reboot_state", 64'(state), 64'(ST_BOOT));
        tick();
        check("reboot_run", 64'(state), 64'(ST_RUN));
        check("reboot_pc", 64'(fetch_pc), 64'h1000);
        check("reboot_credits", 64'(credits), 64'(QD));
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
